// File: rtl/spi_slave_module.sv
// Mode-0 SPI slave: 8-bit command plus 32 data bits, oversampled in the clk domain.
// Optional SPI_READBACK_EN: shift out the selected register's pre-frame value in the data phase.
module spi_slave_module (
   input  logic        clk,
   input  logic        nrst,
   input  logic        sck,
   input  logic        mosi,
   input  logic        ncs,
   output logic        miso,
   output logic [7:0]  q_c,
   output logic [31:0] q_0,
   output logic [31:0] q_1
);

   logic [2:0]  sck_q;
   logic [1:0]  mosi_q;
   logic [2:0]  ncs_q;

   logic        act_q,  act_d;
   logic [5:0]  cnt_q,  cnt_d;
   logic [31:0] rx_q,   rx_d;
   logic [31:0] tx_q,   tx_d;
   logic        miso_q, miso_d;
   logic [7:0]  qc_q,   qc_d;
   logic [31:0] q0_q,   q0_d;
   logic [31:0] q1_q,   q1_d;

   logic        sck_rise, sck_fall, ncs_rise, ncs_fall, mosi_s;
   logic [7:0]  cmd_byte;
   logic [31:0] rd_word;

   // Stage [1] is the synchronized level, stage [2] the previous one for edge detection.
   assign sck_rise = sck_q[1] & ~sck_q[2];
   assign sck_fall = ~sck_q[1] & sck_q[2];
   assign ncs_fall = ~ncs_q[1] & ncs_q[2];
   assign ncs_rise = ncs_q[1] & ~ncs_q[2];
   assign mosi_s   = mosi_q[1];
   assign cmd_byte = {rx_q[6:0], mosi_s};

`ifdef SPI_READBACK_EN
   assign rd_word = mosi_s ? q1_q : q0_q;
`else
   assign rd_word = 32'd0;
`endif

   // tx_q holds the bits still to be sent; miso_q is the bit currently on the wire.
   always_comb begin
      act_d  = act_q;
      cnt_d  = cnt_q;
      rx_d   = rx_q;
      tx_d   = tx_q;
      miso_d = miso_q;
      qc_d   = qc_q;
      q0_d   = q0_q;
      q1_d   = q1_q;
      if (ncs_fall) begin
         act_d  = 1'b1;
         cnt_d  = 6'd0;
         tx_d   = {qc_q[6:0], 25'd0};
         miso_d = qc_q[7];
      end else if (ncs_rise) begin
         act_d  = 1'b0;
         miso_d = 1'b0;
         tx_d   = 32'd0;
         if (act_q && (cnt_q == 6'd40) && qc_q[7]) begin
            if (qc_q[0]) q1_d = rx_q;
            else         q0_d = rx_q;
         end
      end else if (act_q) begin
         if (sck_rise) begin
            rx_d = {rx_q[30:0], mosi_s};
            if (cnt_q != 6'd63) cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd7) begin
               qc_d   = cmd_byte;
               tx_d   = rd_word;
               miso_d = rd_word[31];
            end
         end else if (sck_fall) begin
            miso_d = tx_q[31];
            tx_d   = {tx_q[30:0], 1'b0};
         end
      end
   end

   // Synchronizer reset levels keep a frame that was cut by reset from restarting mid-way.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sck_q  <= 3'd0;
         mosi_q <= 2'd0;
         ncs_q  <= 3'd0;
         act_q  <= 1'b0;
         cnt_q  <= 6'd0;
         rx_q   <= 32'd0;
         tx_q   <= 32'd0;
         miso_q <= 1'b0;
         qc_q   <= 8'd0;
         q0_q   <= 32'd0;
         q1_q   <= 32'd0;
      end else begin
         sck_q  <= {sck_q[1:0], sck};
         mosi_q <= {mosi_q[0], mosi};
         ncs_q  <= {ncs_q[1:0], ncs};
         act_q  <= act_d;
         cnt_q  <= cnt_d;
         rx_q   <= rx_d;
         tx_q   <= tx_d;
         miso_q <= miso_d;
         qc_q   <= qc_d;
         q0_q   <= q0_d;
         q1_q   <= q1_d;
      end
   end

   assign miso = miso_q;
   assign q_c  = qc_q;
   assign q_0  = q0_q;
   assign q_1  = q1_q;

endmodule

// File: tb/tb_spi_slave_module.sv
// Randomized scoreboard bench for spi_slave_module; honours SPI_READBACK_EN like the design.
module tb_spi_slave_module;

   logic        clk = 1'b0;
   logic        nrst;
   logic        sck = 1'b0;
   logic        mosi = 1'b0;
   logic        ncs = 1'b1;
   logic        miso;
   logic [7:0]  q_c;
   logic [31:0] q_0, q_1;

   int checks = 0;
   int errors = 0;

`ifdef SPI_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   typedef struct {
      int          nbits;
      logic [7:0]  st;
      logic [31:0] dat;
      logic [7:0]  qc;
      logic [31:0] q0;
      logic [31:0] q1;
   } exp_t;

   exp_t sbq[$];

   logic [7:0]  m_qc = 8'd0;
   logic [31:0] m_q0 = 32'd0;
   logic [31:0] m_q1 = 32'd0;

   spi_slave_module dut (
      .clk  (clk),
      .nrst (nrst),
      .sck  (sck),
      .mosi (mosi),
      .ncs  (ncs),
      .miso (miso),
      .q_c  (q_c),
      .q_0  (q_0),
      .q_1  (q_1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: what the slave should return and hold after a frame of n bits.
   task automatic push_expect(input logic [7:0] cmd, input logic [31:0] dat, input int n);
      exp_t e;
      e.nbits = n;
      e.st    = m_qc;
      e.dat   = RB ? (cmd[0] ? m_q1 : m_q0) : 32'd0;
      if (n >= 8) m_qc = cmd;
      if (n == 40 && cmd[7]) begin
         if (cmd[0]) m_q1 = dat;
         else        m_q0 = dat;
      end
      e.qc = m_qc;
      e.q0 = m_q0;
      e.q1 = m_q1;
      sbq.push_back(e);
   endtask

   task automatic spi_bits(input logic [7:0] cmd, input logic [31:0] dat, input int n);
      logic [39:0] w;
      w = {cmd, dat};
      for (int i = 0; i < n; i++) begin
         mosi = (i < 40) ? w[39-i] : 1'($urandom);
         #137 sck = 1'b1;
         #137 sck = 1'b0;
      end
   endtask

   task automatic frame(input logic [7:0] cmd, input logic [31:0] dat, input int n);
      push_expect(cmd, dat, n);
      ncs = 1'b0;
      spi_bits(cmd, dat, n);
      #137 ncs = 1'b1;
      #300;
   endtask

   // Monitor: collects miso at master rising edges, compares at end of each frame.
   initial begin : monitor
      int          nb;
      logic [7:0]  st;
      logic [31:0] dt;
      exp_t        e;
      forever begin
         @(negedge ncs);
         nb = 0; st = 8'd0; dt = 32'd0;
         while (ncs === 1'b0) begin
            @(posedge sck or posedge ncs);
            if (ncs === 1'b0) begin
               if (nb < 8)       st = {st[6:0], miso};
               else if (nb < 40) dt = {dt[30:0], miso};
               nb++;
            end
         end
         repeat (8) @(posedge clk);
         #1;
         if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: frame seen with no expectation queued");
         end else begin
            e = sbq.pop_front();
            chk("bitcount", 32'(nb), 32'(e.nbits));
            if (nb >= 8)  chk("status", {24'd0, st}, {24'd0, e.st});
            if (nb >= 40) chk("rdata", dt, e.dat);
            chk("q_c", {24'd0, q_c}, {24'd0, e.qc});
            chk("q_0", q_0, e.q0);
            chk("q_1", q_1, e.q1);
            chk("miso_idle", {31'd0, miso}, 32'd0);
         end
      end
   end

   initial begin : watchdog
      #3_000_000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : stim
      int n;
      logic [7:0]  rc;
      logic [31:0] rd;
      nrst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_q_c", {24'd0, q_c}, 32'd0);
      chk("rst_q_0", q_0, 32'd0);
      chk("rst_q_1", q_1, 32'd0);
      chk("rst_miso", {31'd0, miso}, 32'd0);
      @(negedge clk);
      nrst = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("idle_miso", {31'd0, miso}, 32'd0);
      chk("idle_q_c", {24'd0, q_c}, 32'd0);

      frame(8'hA0, 32'h24AF55AA, 40);
      frame(8'h51, 32'h01234567, 40);
      frame(8'h81, 32'hDEADBEEF, 40);
      frame(8'h00, 32'h00000000, 40);
      frame(8'h80, 32'h00012345, 28);

      // Reset in the middle of a frame: status already received, then everything clears.
      push_expect(8'hC1, 32'h0, 12);
      sbq[sbq.size()-1].qc = 8'd0;
      sbq[sbq.size()-1].q0 = 32'd0;
      sbq[sbq.size()-1].q1 = 32'd0;
      m_qc = 8'd0; m_q0 = 32'd0; m_q1 = 32'd0;
      ncs = 1'b0;
      spi_bits(8'hC1, 32'h0, 12);
      #50 nrst = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_q_c", {24'd0, q_c}, 32'd0);
      chk("midrst_q_0", q_0, 32'd0);
      chk("midrst_q_1", q_1, 32'd0);
      chk("midrst_miso", {31'd0, miso}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      nrst = 1'b1;
      #137 ncs = 1'b1;
      #300;

      frame(8'hA0, 32'h24AF55AA, 40);

      for (int k = 0; k < 12; k++) begin
         rc = 8'($urandom_range(0, 255));
         rd = $urandom;
         n  = ($urandom_range(0, 3) != 0) ? 40 : int'($urandom_range(0, 45));
         frame(rc, rd, n);
      end

      for (int k = 0; k < 1000 && sbq.size() != 0; k++) @(posedge clk);
      if (sbq.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain: %0d expectations left, required 0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
